q_update_arbiter: RTL and testbench

- Shares one Q-function update datapath (q_function_top) between N_REQ requesters.
- Round-robin arbitration; the winner's X/T/N/alpha operands are latched and driven to the datapath, followed by a one-cycle inform_valid pulse.
- Waits the fixed datapath latency, captures Q, and returns it with the requester ID over a valid/ready response channel.
- Sits between the agent-side request sources and the datapath instance.

---
 rtl/q_arb_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/q_update_arbiter.sv | 165 ++++++++++++++++
 tb/tb_q_update_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/q_arb_pkg.sv
// Shared state encoding, width defaults and helpers for the Q-update arbiter.
package q_arb_pkg;

  localparam int Q_ARB_DATA_W = 32;
  // Wide enough for DP_LATENCY-1 with DP_LATENCY up to 255.
  localparam int Q_ARB_CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } q_arb_state_e;

  function automatic int q_arb_id_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr_i, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] gnt_oh_o,
  output logic [ID_W-1:0]  gnt_idx_o,
  output logic             any_gnt_o
);

  localparam int unsigned NR = N_REQ;

  int unsigned idx;

  // Scan from the farthest offset down so the offset nearest ptr_i wins last.
  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    any_gnt_o = |req_i;
    idx       = 0;
    for (int unsigned k = NR; k > 0; k--) begin
      idx = 32'(ptr_i) + k - 1;
      if (idx >= NR) idx = idx - NR;
      if (req_i[idx]) begin
        gnt_oh_o      = '0;
        gnt_oh_o[idx] = 1'b1;
        gnt_idx_o     = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/q_update_arbiter.sv
// Round-robin front end sharing one Q-update datapath among N_REQ requesters.
// Define Q_ARB_STATS_EN to add per-requester grant counters (grant_count/stats_clr).
module q_update_arbiter
  import q_arb_pkg::*;
#(
  parameter  int N_REQ      = 4,
  parameter  int DATA_W     = Q_ARB_DATA_W,
  parameter  int DP_LATENCY = 4,
  localparam int ID_W       = q_arb_id_w(N_REQ)
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_x,
  input  logic [N_REQ*DATA_W-1:0] req_t,
  input  logic [N_REQ*DATA_W-1:0] req_n,
  input  logic [N_REQ*DATA_W-1:0] req_alpha,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [ID_W-1:0]         resp_id,
  output logic [DATA_W-1:0]       resp_q,
  output logic [DATA_W-1:0]       dp_x,
  output logic [DATA_W-1:0]       dp_t,
  output logic [DATA_W-1:0]       dp_n,
  output logic [DATA_W-1:0]       dp_alpha,
  output logic                    dp_inform_valid,
  input  logic [DATA_W-1:0]       dp_q,
  output logic                    busy
`ifdef Q_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0]     grant_count,
  input  logic                    stats_clr
`endif
);

  localparam int CNT_W = Q_ARB_CNT_W;

  q_arb_state_e      state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] dp_x_q, dp_t_q, dp_n_q, dp_alpha_q;
  logic [DATA_W-1:0] resp_q_q;
  logic [ID_W-1:0]   resp_id_q;

  logic [N_REQ-1:0]  gnt_oh;
  logic [ID_W-1:0]   gnt_idx;
  logic              any_gnt;
  logic              hs;
  logic              capture;
  logic [DATA_W-1:0] sel_x, sel_t, sel_n, sel_alpha;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .req_i     (req_valid),
    .ptr_i     (rr_ptr_q),
    .gnt_oh_o  (gnt_oh),
    .gnt_idx_o (gnt_idx),
    .any_gnt_o (any_gnt)
  );

  assign hs      = (state_q == IDLE) && any_gnt;
  assign capture = (state_q == WAIT) && (cnt_q == '0);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:  if (any_gnt) state_d = ISSUE;
      ISSUE: begin
        cnt_d   = CNT_W'(DP_LATENCY - 1);
        state_d = WAIT;
      end
      WAIT:  begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RESP:  if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // req_ready is gated by areset so it is 0 during reset even with req_valid high.
  always_comb begin
    req_ready       = '0;
    dp_inform_valid = 1'b0;
    resp_valid      = 1'b0;
    busy            = (state_q != IDLE);
    if (state_q == IDLE && !areset) req_ready = gnt_oh;
    if (state_q == ISSUE)           dp_inform_valid = 1'b1;
    if (state_q == RESP)            resp_valid = 1'b1;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (N_REQ == 1)  rr_ptr_d = '0;
    else if (hs)     rr_ptr_d = (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
  end

  always_comb begin
    sel_x     = '0;
    sel_t     = '0;
    sel_n     = '0;
    sel_alpha = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt_oh[i]) begin
        sel_x     = sel_x     | req_x[i*DATA_W +: DATA_W];
        sel_t     = sel_t     | req_t[i*DATA_W +: DATA_W];
        sel_n     = sel_n     | req_n[i*DATA_W +: DATA_W];
        sel_alpha = sel_alpha | req_alpha[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
      dp_x_q     <= '0;
      dp_t_q     <= '0;
      dp_n_q     <= '0;
      dp_alpha_q <= '0;
      resp_id_q  <= '0;
      resp_q_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      if (hs) begin
        dp_x_q     <= sel_x;
        dp_t_q     <= sel_t;
        dp_n_q     <= sel_n;
        dp_alpha_q <= sel_alpha;
        resp_id_q  <= gnt_idx;
      end
      if (capture) resp_q_q <= dp_q;
    end
  end

  assign dp_x     = dp_x_q;
  assign dp_t     = dp_t_q;
  assign dp_n     = dp_n_q;
  assign dp_alpha = dp_alpha_q;
  assign resp_id  = resp_id_q;
  assign resp_q   = resp_q_q;

`ifdef Q_ARB_STATS_EN
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stats
    logic [15:0] gcnt_q;
    always_ff @(posedge aclk or posedge areset) begin
      if (areset)                                gcnt_q <= '0;
      else if (stats_clr)                        gcnt_q <= '0;
      else if (hs && gnt_oh[gi] && gcnt_q != '1) gcnt_q <= gcnt_q + 1'b1;
    end
    assign grant_count[gi*16 +: 16] = gcnt_q;
  end
`endif

endmodule

// File: tb/tb_q_update_arbiter.sv
// Randomized self-checking bench for q_update_arbiter against a queue-based reference model.
module tb_q_update_arbiter;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int L   = 4;
  localparam int IDW = 2;

  logic             aclk = 1'b0;
  logic             areset;
  logic [N-1:0]     req_valid, req_ready;
  logic [N*W-1:0]   req_x, req_t, req_n, req_alpha;
  logic             resp_valid, resp_ready;
  logic [IDW-1:0]   resp_id;
  logic [W-1:0]     resp_q;
  logic [W-1:0]     dp_x, dp_t, dp_n, dp_alpha, dp_q;
  logic             dp_inform_valid, busy;
`ifdef Q_ARB_STATS_EN
  logic [N*16-1:0]  grant_count;
  logic             stats_clr;
`endif

  logic [W-1:0] ox[N], ot[N], on_[N], oa[N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_x[i*W +: W]     = ox[i];
      req_t[i*W +: W]     = ot[i];
      req_n[i*W +: W]     = on_[i];
      req_alpha[i*W +: W] = oa[i];
    end
  end

  q_update_arbiter #(
    .N_REQ      (N),
    .DATA_W     (W),
    .DP_LATENCY (L)
  ) dut (
    .aclk            (aclk),
    .areset          (areset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_x           (req_x),
    .req_t           (req_t),
    .req_n           (req_n),
    .req_alpha       (req_alpha),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_id         (resp_id),
    .resp_q          (resp_q),
    .dp_x            (dp_x),
    .dp_t            (dp_t),
    .dp_n            (dp_n),
    .dp_alpha        (dp_alpha),
    .dp_inform_valid (dp_inform_valid),
    .dp_q            (dp_q),
    .busy            (busy)
`ifdef Q_ARB_STATS_EN
    ,
    .grant_count     (grant_count),
    .stats_clr       (stats_clr)
`endif
  );

  always #5 aclk = ~aclk;

  // Datapath stub: sum of operands exactly L cycles after the pulse, garbage otherwise.
  logic [L-1:0] pulse_hist;
  always @(posedge aclk or posedge areset) begin
    if (areset) pulse_hist <= '0;
    else        pulse_hist <= {pulse_hist[L-2:0], dp_inform_valid};
  end
  assign dp_q = pulse_hist[L-1] ? (dp_x + dp_t + dp_n + dp_alpha) : 32'hDEADBEEF;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model state
  typedef struct {
    int       id;
    logic [W-1:0] q;
  } exp_t;
  exp_t       exp_q[$];
  int         glog[$];
  int         gcount[N];
  int         m_ptr   = 0;
  bit         m_busy  = 1'b0;
  int         hs_cyc  = 0;
  int         nresp   = 0;
  int         last_id = -1;
  logic [W-1:0] last_q = '0;
  int         last_lat = 0;
  logic [N-1:0] hs_vec = '0;

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  initial begin
    int g, d;
    forever begin
      @(negedge aclk);
      if (areset) begin
        hs_vec = '0;
        continue;
      end
      hs_vec = req_ready & req_valid;
      if (!m_busy) begin
        chk("idle_out", {busy, resp_valid, dp_inform_valid}, 0);
        if (|req_valid) begin
          g = pick(req_valid, m_ptr);
          chk("grant", req_ready, 1 << g);
          exp_q.push_back('{g, ox[g] + ot[g] + on_[g] + oa[g]});
          glog.push_back(g);
          gcount[g]++;
          m_ptr  = (g + 1) % N;
          m_busy = 1'b1;
          hs_cyc = cyc;
        end else begin
          chk("no_grant", req_ready, 0);
        end
      end else begin
        d = cyc - hs_cyc;
        chk("busy_rdy", {busy, req_ready}, {1'b1, 4'b0});
        chk("pulse", dp_inform_valid, (d == 1));
        if (d <= L + 1) begin
          chk("early_resp", resp_valid, 0);
        end else begin
          chk("resp_valid", resp_valid, 1);
          chk("resp_id", resp_id, exp_q[0].id);
          chk("resp_q", resp_q, exp_q[0].q);
          if (resp_ready) begin
            last_id  = int'(resp_id);
            last_q   = resp_q;
            last_lat = d;
            void'(exp_q.pop_front());
            m_busy = 1'b0;
            nresp++;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic new_ops(input int i);
    ox[i]  = $urandom;
    ot[i]  = $urandom;
    on_[i] = $urandom;
    oa[i]  = $urandom;
  endtask

  task automatic wait_grant(input int budget);
    int base = glog.size();
    int n = 0;
    while (glog.size() == base && n < budget) begin
      step();
      n++;
    end
    chk("grant_timeout", glog.size() > base, 1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((m_busy || busy) && n < budget) begin
      step();
      n++;
    end
    chk("idle_timeout", m_busy, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {resp_valid, resp_id, resp_q, busy, dp_inform_valid, req_ready}, 0);
    chk({tag, "_dp0"}, {dp_x, dp_t}, 0);
    chk({tag, "_dp1"}, {dp_n, dp_alpha}, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, n, nr0, g1b;
    int order[6] = '{0, 1, 2, 3, 0, 1};
    logic [W-1:0] bp_sum;

    areset     = 1'b1;
    req_valid  = '0;
    resp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      ox[i] = '0; ot[i] = '0; on_[i] = '0; oa[i] = '0; gcount[i] = 0;
    end
`ifdef Q_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    #1;
    chk_zero("reset");
    repeat (3) step();
    areset = 1'b0;
    step();
    chk_zero("post_reset");

    // Round robin: everyone valid, grants rotate from pointer 0
    for (int i = 0; i < N; i++) begin
      ox[i] = 32'(i * 10 + 1); ot[i] = 1; on_[i] = 2; oa[i] = 3;
    end
    req_valid  = '1;
    resp_ready = 1'b1;
    base = glog.size();
    n = 0;
    while (glog.size() < base + 6 && n < 200) begin
      step();
      n++;
    end
    req_valid = '0;
    chk("rr_timeout", glog.size() >= base + 6, 1);
    if (glog.size() >= base + 6)
      for (int k = 0; k < 6; k++) chk("rr_order", glog[base + k], order[k]);
    wait_idle(100);

    // Single request from requester 2
    ox[2] = 32; ot[2] = 55; on_[2] = 101; oa[2] = 2;
    req_valid = 4'b0100;
    wait_grant(50);
    req_valid = '0;
    wait_idle(100);
    chk("single_id", last_id, 2);
    chk("single_q", last_q, 190);
    chk("single_lat", last_lat, L + 2);

    // Backpressure: response held 20 cycles, requester 1 waiting
    resp_ready = 1'b0;
    ox[0] = 32'h1000; ot[0] = 32'h0200; on_[0] = 32'h0030; oa[0] = 32'h0004;
    bp_sum = 32'h1234;
    req_valid = 4'b0001;
    wait_grant(50);
    new_ops(1);
    req_valid = 4'b0010;
    n = 0;
    while (!resp_valid && n < 50) begin
      step();
      n++;
    end
    repeat (20) step();
    chk("bp_valid", resp_valid, 1);
    chk("bp_q", resp_q, bp_sum);
    chk("bp_id", resp_id, 0);
    chk("bp_rdy", req_ready, 0);
    resp_ready = 1'b1;
    wait_grant(50);
    chk("bp_next", glog[glog.size() - 1], 1);
    req_valid = '0;
    wait_idle(100);

    // Reset during WAIT
    new_ops(2);
    req_valid = 4'b0100;
    wait_grant(50);
    req_valid = '0;
    n = 0;
    while (cyc - hs_cyc < 3 && n < 20) begin
      step();
      n++;
    end
    req_valid = 4'b0001;
    areset = 1'b1;
    exp_q.delete();
    m_busy = 1'b0;
    m_ptr  = 0;
    #1;
    chk_zero("mid_reset");
    nr0 = nresp;
    repeat (2) step();
    req_valid = '0;
    areset = 1'b0;
    repeat (30) step();
    chk("no_resp_after_reset", nresp, nr0);
    new_ops(1);
    new_ops(3);
    req_valid = 4'b1010;
    wait_grant(50);
    chk("post_rst_ptr0", glog[glog.size() - 1], 1);
    req_valid = 4'b1000;
    wait_grant(50);
    chk("post_rst_r3", glog[glog.size() - 1], 3);
    req_valid = '0;
    wait_idle(100);
    chk("post_rst_r3_id", last_id, 3);

    // Withdrawn request: requester 1 pulses while busy
    new_ops(0);
    req_valid = 4'b0001;
    wait_grant(50);
    g1b = gcount[1];
    step();
    new_ops(1);
    req_valid[1] = 1'b1;
    step();
    req_valid[1] = 1'b0;
    wait_grant(50);
    chk("wd_owner", glog[glog.size() - 1], 0);
    chk("wd_no_r1", gcount[1], g1b);
    req_valid = '0;
    wait_idle(100);

    // Randomized traffic with random backpressure and withdrawals
    repeat (800) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (req_valid[i]) begin
          if (hs_vec[i]) begin
            req_valid[i] = 1'($urandom % 2);
            new_ops(i);
          end else if ($urandom % 100 < 3) begin
            req_valid[i] = 1'b0;
          end
        end else if ($urandom % 100 < 25) begin
          new_ops(i);
          req_valid[i] = 1'b1;
        end
      end
      resp_ready = ($urandom % 100 < 70);
    end
    req_valid  = '0;
    resp_ready = 1'b1;
    wait_idle(100);
    chk("drain_empty", exp_q.size(), 0);

`ifdef Q_ARB_STATS_EN
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    chk("st_clr0", grant_count, 0);
    new_ops(1);
    req_valid = 4'b0010;
    repeat (5) wait_grant(50);
    req_valid = '0;
    wait_idle(100);
    for (int i = 0; i < N; i++)
      chk("st_cnt", grant_count[i*16 +: 16], (i == 1) ? 5 : 0);
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    chk("st_clr", grant_count, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
